// File: rtl/cpu_pkg.sv
// Shared CPU types: branch-history-table entry layout, counter encoding and
// the decoder's branch-type classification.
package cpu_pkg;

  localparam int BHT_ADDR_W  = 10;
  localparam int BHT_INDEX_W = 5;
  localparam int BHT_TAG_W   = BHT_ADDR_W - BHT_INDEX_W;

  localparam logic [3:0] BRANCH_TYPE_MAX = 4'h9;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  typedef struct packed {
    logic                  valid;
    logic [BHT_TAG_W-1:0]  tag;
    bht_ctr_t              ctr;
    logic [BHT_ADDR_W-1:0] target;
  } bht_entry_t;

  typedef enum logic {
    BHT_CLEAR = 1'b0,
    BHT_READY = 1'b1
  } bht_state_t;

  // Branch types 1..BRANCH_TYPE_MAX are resolved branches that train the BHT.
  function automatic logic is_branch(input logic [3:0] br_type);
    return (br_type != 4'h0) && (br_type <= BRANCH_TYPE_MAX);
  endfunction

endpackage

// File: rtl/bht_predictor_sat_ctr2.sv
// Two-bit saturating branch counter: next state from current state and outcome.
module sat_ctr2
  import cpu_pkg::*;
(
  input  bht_ctr_t ctr_i,
  input  logic     taken_i,
  output bht_ctr_t ctr_o
);

  function automatic bht_ctr_t sat_step(input bht_ctr_t c, input logic t);
    logic [1:0] v;
    v = c;
    if (t) begin
      if (v != 2'b11) v = v + 2'b01;
    end else begin
      if (v != 2'b00) v = v - 2'b01;
    end
    return bht_ctr_t'(v);
  endfunction

  assign ctr_o = sat_step(ctr_i, taken_i);

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped tagged 2-bit branch history table with stored targets.
// Combinational lookup for fetch, single write port shared by clear sweep and training.
module bht_predictor
  import cpu_pkg::*;
#(
  parameter int         ADDR_W   = BHT_ADDR_W,
  parameter int         INDEX_W  = BHT_INDEX_W,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  output logic              prediction,
  output logic [ADDR_W-1:0] pred_target,
  output logic              hit,
  input  logic              upd_we,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              clear_busy
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = ADDR_W - INDEX_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    bht_ctr_t          ctr;
    logic [ADDR_W-1:0] target;
  } entry_t;

  bht_state_t         state_q, state_d;
  logic [INDEX_W-1:0] clr_idx_q, clr_idx_d;
  entry_t             tbl_q [ENTRIES];

  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx;
  entry_t             wr_entry;

  // Lookup: async read of the registered table, masked while the sweep runs.
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  entry_t             lk_entry;

  assign lk_idx      = pc[INDEX_W-1:0];
  assign lk_tag      = pc[ADDR_W-1:INDEX_W];
  assign lk_entry    = tbl_q[lk_idx];
  assign clear_busy  = (state_q == BHT_CLEAR);
  assign hit         = ~clear_busy & lk_entry.valid & (lk_entry.tag == lk_tag);
  assign prediction  = hit & lk_entry.ctr[1];
  assign pred_target = clear_busy ? '0 : lk_entry.target;

  // Training: read-modify-write of the resolved branch's entry.
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  entry_t             up_entry;
  logic               up_hit;
  bht_ctr_t           up_ctr_trained;

  assign up_idx   = upd_pc[INDEX_W-1:0];
  assign up_tag   = upd_pc[ADDR_W-1:INDEX_W];
  assign up_entry = tbl_q[up_idx];
  assign up_hit   = up_entry.valid & (up_entry.tag == up_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr_i   (up_entry.ctr),
    .taken_i (upd_taken),
    .ctr_o   (up_ctr_trained)
  );

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_en     = 1'b0;
    wr_idx    = up_idx;
    wr_entry  = up_entry;
    if (rst || flush) begin
      state_d   = BHT_CLEAR;
      clr_idx_d = '0;
    end else if (state_q == BHT_CLEAR) begin
      wr_en          = 1'b1;
      wr_idx         = clr_idx_q;
      wr_entry       = '0;
      wr_entry.ctr   = bht_ctr_t'(INIT_CTR);
      clr_idx_d      = clr_idx_q + 1'b1;
      if (clr_idx_q == INDEX_W'(ENTRIES - 1)) state_d = BHT_READY;
    end else if (upd_we) begin
      wr_en = 1'b1;
      if (up_hit) begin
        wr_entry.ctr = up_ctr_trained;
      end else begin
        // Miss or invalid: allocate, keeping the old target on a not-taken outcome.
        wr_entry.valid = 1'b1;
        wr_entry.tag   = up_tag;
        wr_entry.ctr   = upd_taken ? WT : bht_ctr_t'(INIT_CTR);
      end
      if (upd_taken) wr_entry.target = upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BHT_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[wr_idx] <= wr_entry;
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor: stimulus pushes expected lookup results
// from a table-level reference model; a negedge monitor pops and compares.
module tb_bht_predictor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] pc = '0;
  logic       prediction;
  logic [9:0] pred_target;
  logic       hit;
  logic       upd_we = 1'b0;
  logic [9:0] upd_pc = '0;
  logic       upd_taken = 1'b0;
  logic [9:0] upd_target = '0;
  logic       clear_busy;

  always #5 clk = ~clk;

  bht_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .pc          (pc),
    .prediction  (prediction),
    .pred_target (pred_target),
    .hit         (hit),
    .upd_we      (upd_we),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .clear_busy  (clear_busy)
  );

  typedef struct {
    string      nm;
    logic       busy;
    logic       hit;
    logic       pred;
    logic [9:0] tgt;
    bit         chk_tgt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: per-index valid/tag/counter/target, plus a busy countdown.
  bit m_valid [32];
  int m_tag   [32];
  int m_ctr   [32];
  int m_tgt   [32];
  int busy_cnt = 0;
  bit known = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.nm, ".busy"}, 32'(clear_busy), 32'(e.busy));
      check({e.nm, ".hit"},  32'(hit),        32'(e.hit));
      check({e.nm, ".pred"}, 32'(prediction), 32'(e.pred));
      if (e.chk_tgt) check({e.nm, ".tgt"}, 32'(pred_target), 32'(e.tgt));
    end
  end

  task automatic step(input bit r, input bit f, input logic [9:0] lpc, input bit we,
                      input logic [9:0] upc, input bit tk, input logic [9:0] utg,
                      input string nm);
    exp_t e;
    int   li, ui;
    @(posedge clk);
    #1;
    rst = r; flush = f; pc = lpc;
    upd_we = we; upd_pc = upc; upd_taken = tk; upd_target = utg;
    li = int'(lpc) % 32;
    if (known) begin
      e.nm = nm;
      if (busy_cnt > 0) begin
        e.busy = 1'b1; e.hit = 1'b0; e.pred = 1'b0; e.tgt = '0; e.chk_tgt = 1'b1;
      end else begin
        e.busy    = 1'b0;
        e.hit     = m_valid[li] && (m_tag[li] == int'(lpc) / 32);
        e.pred    = e.hit && (m_ctr[li] >= 2);
        e.tgt     = 10'(m_tgt[li]);
        e.chk_tgt = e.pred;
      end
      sb.push_back(e);
    end
    if (r || f) begin
      known    = 1;
      busy_cnt = 32;
      for (int i = 0; i < 32; i++) m_valid[i] = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end else if (we) begin
      ui = int'(upc) % 32;
      if (m_valid[ui] && m_tag[ui] == int'(upc) / 32) begin
        m_ctr[ui] = tk ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                       : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
      end else begin
        m_valid[ui] = 1;
        m_tag[ui]   = int'(upc) / 32;
        m_ctr[ui]   = tk ? 2 : 1;
      end
      if (tk) m_tgt[ui] = int'(utg);
    end
  endtask

  task automatic look(input logic [9:0] lpc, input string nm);
    step(0, 0, lpc, 0, '0, 0, '0, nm);
  endtask

  task automatic upd(input logic [9:0] upc, input bit tk, input logic [9:0] utg, input string nm);
    step(0, 0, upc, 1, upc, tk, utg, nm);
  endtask

  function automatic logic [9:0] pool_pc();
    return {3'($urandom_range(0, 3)), 2'b00, 5'($urandom_range(0, 7))};
  endfunction

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0; end

    // Reset, then the full sweep followed by empty-table lookups.
    step(1, 0, '0, 0, '0, 0, '0, "rst");
    for (int i = 0; i < 34; i++) look(10'($urandom_range(0, 1023)), "sweep");
    look(10'h045, "empty045");
    look(10'h3FF, "empty3FF");

    // Allocate taken, then lookup.
    upd(10'h045, 1, 10'h120, "alloc");
    look(10'h045, "hit045");

    // Train to ST, then walk down with not-taken outcomes.
    upd(10'h045, 1, 10'h120, "toST");
    look(10'h045, "st045");
    for (int i = 0; i < 4; i++) begin
      upd(10'h045, 0, 10'h3AB, "nt");
      look(10'h045, "ntwalk");
    end

    // Aliasing on index 5.
    upd(10'h045, 1, 10'h155, "alias_a");
    upd(10'h065, 0, 10'h000, "alias_b");
    look(10'h045, "alias045");
    look(10'h065, "alias065");

    // Same-cycle lookup and update from WNT.
    upd(10'h045, 0, 10'h000, "mkwnt");
    look(10'h045, "wnt045");
    step(0, 0, 10'h045, 1, 10'h045, 1, 10'h2C3, "samecyc");
    look(10'h045, "aftersame");

    // Flush mid-sweep and updates during the sweep.
    step(1, 0, '0, 0, '0, 0, '0, "rst2");
    for (int i = 0; i < 10; i++) look(10'h045, "presweep");
    step(0, 1, 10'h045, 1, 10'h0AA, 1, 10'h111, "flush");
    for (int i = 0; i < 5; i++) step(0, 0, 10'h0AA, 1, 10'h0AA, 1, 10'h111, "updclr");
    for (int i = 0; i < 29; i++) look(10'h0AA, "postflush");
    look(10'h0AA, "dropped");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit r, f;
      r = ($urandom_range(0, 299) == 0);
      f = ($urandom_range(0, 199) == 0);
      step(r, f, pool_pc(), 1'($urandom_range(0, 1)), pool_pc(),
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), "rand");
    end

    @(posedge clk);
    #1;
    rst = 0; flush = 0; upd_we = 0;
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
